// File: rtl/fifo_sync_param_if.sv
// Handshake/status bundle between a producer/consumer pair and fifo_sync_param.
// The master side drives requests; the slave side (the FIFO) returns data and status.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) ();
  logic                   flush;
  logic                   wen;
  logic                   ren;
  logic [DATA_WIDTH-1:0]  data_in;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [ADDRESS_WIDTH:0] count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output flush, wen, ren, data_in,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wen, ren, data_in,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, over/underflow pulses
// and synchronous flush. Define FIFO_FWFT_EN for first-word fall-through output.
module fifo_sync_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int AF_LEVEL      = (2 ** ADDRESS_WIDTH) - 2,
  parameter int AE_LEVEL      = 2
) (
  input  logic              clock,
  input  logic              reset,
  fifo_sync_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int PW    = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic [PW-1:0]            count_w;
  logic                     full_w, empty_w;
  logic                     wr_acc, rd_acc;
  logic [ADDRESS_WIDTH-1:0] wr_addr, rd_addr;

  // Extra wrap bit lets the plain difference distinguish full from empty.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (count_w == PW'(DEPTH));
  assign empty_w = (count_w == '0);
  assign wr_addr = wr_ptr_q[ADDRESS_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDRESS_WIDTH-1:0];

  always_comb begin
    wr_acc      = bus.wen && !full_w && !bus.flush;
    rd_acc      = bus.ren && !empty_w && !bus.flush;
    overflow_d  = bus.wen && full_w && !bus.flush;
    underflow_d = bus.ren && empty_w && !bus.flush;
    wr_ptr_d    = wr_ptr_q + {{(PW-1){1'b0}}, wr_acc};
    rd_ptr_d    = rd_ptr_q + {{(PW-1){1'b0}}, rd_acc};
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (reset && wr_acc)
      mem[wr_addr] <= bus.data_in;
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = mem[rd_addr];
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc)
      data_out_d = mem[rd_addr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      data_out_q <= '0;
    else
      data_out_q <= data_out_d;
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.count        = count_w;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_w >= PW'(AF_LEVEL));
  assign bus.almost_empty = (count_w <= PW'(AE_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised self-checking bench for fifo_sync_param against a queue-based reference model.
// Build with +define+FIFO_FWFT_EN to exercise the fall-through variant.
module tb_fifo_sync_param;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clock;
  logic reset;

  fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  fifo_sync_param #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;

  // Reference model: contents as a queue, plus the registered outputs.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_unf;

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock of stimulus; model updated from pre-edge occupancy, outputs sampled 1ns later.
  task automatic step(input logic w, input logic r, input logic f, input logic [DW-1:0] d);
    logic wa, ra;
    @(negedge clock);
    bus.wen     = w;
    bus.ren     = r;
    bus.flush   = f;
    bus.data_in = d;
    @(posedge clock);
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      $display("[%0t] flush", $time);
    end else begin
      wa    = w && (mq.size() < DEPTH);
      ra    = r && (mq.size() > 0);
      m_ovf = w && !wa;
      m_unf = r && !ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(d);
      $display("[%0t] wen=%0b ren=%0b din=%h wr_ok=%0b rd_ok=%0b rd_data=%h size=%0d",
               $time, w, r, d, wa, ra, ra ? m_dout : 8'h00, mq.size());
    end
    #1;
  endtask

  function automatic logic [DW-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (mq.size() > 0) ? mq[0] : bus.data_out;
`else
    return m_dout;
`endif
  endfunction

  task automatic test_reset();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b exp 1", bus.almost_empty); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", bus.almost_full); end
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {bus.overflow, bus.underflow}); end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", bus.data_out); end
`endif
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, vals[i]);
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", bus.count); end
    for (int i = 0; i < 3; i++) begin
`ifdef FIFO_FWFT_EN
      checks++; if (bus.data_out !== vals[i]) begin errors++; $display("FAIL basic_head%0d got %h exp %h", i, bus.data_out, vals[i]); end
      step(1'b0, 1'b1, 1'b0, 8'h00);
`else
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (bus.data_out !== vals[i]) begin errors++; $display("FAIL basic_read%0d got %h exp %h", i, bus.data_out, vals[i]); end
`endif
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", bus.empty); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL basic_count0 got %0d exp 0", bus.count); end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", bus.full); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", bus.count); end
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", bus.count); end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
    // Write while full is rejected even though the same-cycle read frees a slot.
    step(1'b1, 1'b1, 1'b0, 8'hEF);
    checks++; if (bus.overflow !== m_ovf || m_ovf !== 1'b1) begin errors++; $display("FAIL ovf_with_pop got %b exp 1", bus.overflow); end
    checks++; if (bus.count !== 5'(mq.size())) begin errors++; $display("FAIL ovf_pop_count got %0d exp %0d", bus.count, mq.size()); end
    while (mq.size() > 0) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (bus.data_out !== exp_dout()) begin errors++; $display("FAIL drain_dout got %h exp %h", bus.data_out, exp_dout()); end
    end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b1, 1'b0, 8'hA5);
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse got %b exp 1", bus.underflow); end
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL unf_count got %0d exp 1", bus.count); end
    step(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL unf_read got %h exp a5", bus.data_out); end
`endif
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", bus.underflow); end
  endtask

  task automatic test_wrap_flags();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'($urandom));
      checks++; if (bus.count !== 5'd8) begin errors++; $display("FAIL wrap_count got %0d exp 8", bus.count); end
      checks++; if (bus.data_out !== exp_dout()) begin errors++; $display("FAIL wrap_dout got %h exp %h", bus.data_out, exp_dout()); end
    end
    // Sweep occupancy 8 -> 16 -> 0 so every flag threshold is crossed.
    for (int i = 0; i < 8 + DEPTH; i++) begin
      if (i < 8) step(1'b1, 1'b0, 1'b0, 8'($urandom));
      else       step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (bus.almost_full !== (mq.size() >= AF)) begin errors++; $display("FAIL af_at_%0d got %b exp %b", mq.size(), bus.almost_full, mq.size() >= AF); end
      checks++; if (bus.almost_empty !== (mq.size() <= AE)) begin errors++; $display("FAIL ae_at_%0d got %b exp %b", mq.size(), bus.almost_empty, mq.size() <= AE); end
      checks++; if (bus.data_out !== exp_dout()) begin errors++; $display("FAIL sweep_dout got %h exp %h", bus.data_out, exp_dout()); end
    end
  endtask

  task automatic test_random();
    logic w, r, f;
    for (int i = 0; i < 200; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 2);
      step(w, r, f, 8'($urandom));
      checks++; if (bus.count !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d", bus.count, mq.size()); end
      checks++; if (bus.full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rnd_full got %b", bus.full); end
      checks++; if (bus.empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty got %b", bus.empty); end
      checks++; if ({bus.overflow, bus.underflow} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rnd_pulses got %b exp %b", {bus.overflow, bus.underflow}, {m_ovf, m_unf}); end
      checks++; if (bus.data_out !== exp_dout()) begin errors++; $display("FAIL rnd_dout got %h exp %h", bus.data_out, exp_dout()); end
    end
  endtask

  task automatic test_flush_reset();
    logic [DW-1:0] held;
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    held = bus.data_out;
    step(1'b1, 1'b1, 1'b1, 8'h77);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", bus.empty); end
    checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin errors++; $display("FAIL flush_pulses got %b exp 00", {bus.overflow, bus.underflow}); end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.data_out !== held) begin errors++; $display("FAIL flush_dout got %h exp %h", bus.data_out, held); end
`endif
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    #2 reset = 1'b0;
    #1;
    model_reset();
    $display("[%0t] async reset asserted", $time);
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL areset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL areset_ae got %b exp 1", bus.almost_empty); end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL areset_dout got %h exp 00", bus.data_out); end
`endif
    @(negedge clock);
    bus.wen = 1'b0; bus.ren = 1'b0; bus.flush = 1'b0;
    reset = 1'b1;
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    checks++; if (bus.data_out !== 8'h5A) begin errors++; $display("FAIL fwft_head got %h exp 5a", bus.data_out); end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fwft_pop got %b exp 1", bus.empty); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset       = 1'b0;
    bus.wen     = 1'b0;
    bus.ren     = 1'b0;
    bus.flush   = 1'b0;
    bus.data_in = '0;
    model_reset();
    repeat (2) @(negedge clock);
    test_reset();
    reset = 1'b1;
    test_basic();
    test_full_overflow();
    test_underflow();
    test_wrap_flags();
    test_random();
    test_flush_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
